io_input_conditioner: RTL and testbench

- Front-end stage feeding the datapath's `IO_input[21:0]` bus (SW 0-17, KEY 18-21) and its DMA apply button input.
- Synchronises raw board switches and keys into `physical_clock` and debounces every line with one shared sample tick.
- Produces single-cycle press pulses for keys and the apply button, plus sticky press latches that the consumer clears with a clear/ack handshake.
- Replaces ad-hoc per-button debouncing with one block.

---
 rtl/io_input_conditioner.sv | 174 +++++++++++++++++
 tb/tb_io_input_conditioner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: 2-flop sync, shared-tick debounce, press pulses and sticky latches for
// switches, keys and the DMA apply button. Optional key auto-repeat under IO_INPUT_AUTOREPEAT_EN.

module io_debounce_line #(
    parameter int STABLE_TICKS = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic synced_i,
    output logic deb_o
);
    localparam int CW = $clog2(STABLE_TICKS + 1);

    typedef enum logic {ST_STABLE, ST_CHANGING} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic [CW:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
    assign deb_o   = deb_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        if (tick_i) begin
            case (state_q)
                ST_STABLE: begin
                    if (synced_i != deb_q) begin
                        state_d = ST_CHANGING;
                        cnt_d   = CW'(1);
                    end
                end
                ST_CHANGING: begin
                    // A sample matching the old level is a bounce: start over.
                    if (synced_i == deb_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == (CW+1)'(STABLE_TICKS)) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                        deb_d   = synced_i;
                    end else begin
                        cnt_d = cnt_inc[CW-1:0];
                    end
                end
            endcase
        end
    end
endmodule

module io_input_conditioner #(
    parameter int NUM_SW         = 18,
    parameter int NUM_KEY        = 4,
    parameter int TICK_CYCLES    = 50000,
    parameter int STABLE_TICKS   = 10,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic                      physical_clock,
    input  logic                      reset,
    input  logic [NUM_SW-1:0]         raw_sw,
    input  logic [NUM_KEY-1:0]        raw_key,
    input  logic                      raw_apply,
    input  logic [NUM_KEY-1:0]        key_clear,
    input  logic                      apply_clear,
    output logic [NUM_SW+NUM_KEY-1:0] IO_input,
    output logic [NUM_KEY-1:0]        key_press,
    output logic [NUM_KEY-1:0]        key_latched,
    output logic                      apply_press,
    output logic                      apply_latched,
    output logic                      sample_tick
);
    localparam int NL = NUM_SW + NUM_KEY + 1;
    localparam int NP = NUM_KEY + 1;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [NL-1:0] INV_MASK =
        (KEY_ACTIVE_LOW != 0) ? {{NP{1'b1}}, {NUM_SW{1'b0}}} : '0;

    logic [NL-1:0] sync1_q, sync2_q, synced, deb;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [NP-1:0] pdeb, prev_q, press_q, press_d, latched_q, latched_d, rpt_fire, clear;

    assign tick       = (tick_cnt_q == TW'(TICK_CYCLES - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    assign synced     = sync2_q ^ INV_MASK;
    assign pdeb       = deb[NL-1:NUM_SW];
    assign clear      = {apply_clear, key_clear};
    assign press_d    = (pdeb & ~prev_q) | rpt_fire;
    // Set has priority over clear on the same cycle.
    assign latched_d  = press_q | (latched_q & ~clear);

    always_ff @(posedge physical_clock) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            prev_q     <= '0;
            press_q    <= '0;
            latched_q  <= '0;
        end else begin
            sync1_q    <= {raw_apply, raw_key, raw_sw};
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            prev_q     <= pdeb;
            press_q    <= press_d;
            latched_q  <= latched_d;
        end
    end

    for (genvar i = 0; i < NL; i++) begin : g_line
        io_debounce_line #(.STABLE_TICKS(STABLE_TICKS)) u_deb (
            .clk_i   (physical_clock),
            .rst_i   (reset),
            .tick_i  (tick),
            .synced_i(synced[i]),
            .deb_o   (deb[i])
        );
    end

`ifdef IO_INPUT_AUTOREPEAT_EN
    localparam logic [8:0] RPT_FIRST = 9'd500;
    localparam logic [8:0] RPT_NEXT  = 9'd100;

    for (genvar k = 0; k < NUM_KEY; k++) begin : g_rpt
        logic [8:0] rcnt_q, rcnt_inc, limit;
        logic       rep_q;

        assign limit       = rep_q ? RPT_NEXT : RPT_FIRST;
        assign rcnt_inc    = rcnt_q + 9'd1;
        assign rpt_fire[k] = tick & pdeb[k] & (rcnt_inc == limit);

        // Counts ticks while the debounced key stays pressed; release clears it.
        always_ff @(posedge physical_clock) begin
            if (reset || !pdeb[k]) begin
                rcnt_q <= '0;
                rep_q  <= 1'b0;
            end else if (tick) begin
                if (rcnt_inc == limit) begin
                    rcnt_q <= '0;
                    rep_q  <= 1'b1;
                end else begin
                    rcnt_q <= rcnt_inc;
                end
            end
        end
    end
    assign rpt_fire[NUM_KEY] = 1'b0;
`else
    assign rpt_fire = '0;
`endif

    assign IO_input      = deb[NUM_SW+NUM_KEY-1:0];
    assign key_press     = press_q[NUM_KEY-1:0];
    assign key_latched   = latched_q[NUM_KEY-1:0];
    assign apply_press   = press_q[NUM_KEY];
    assign apply_latched = latched_q[NUM_KEY];
    assign sample_tick   = tick;
endmodule

// File: tb/tb_io_input_conditioner.sv
// Self-checking bench for io_input_conditioner: randomized stimulus against a tick-level reference model.
module tb_io_input_conditioner;
    localparam int NUM_SW = 18, NUM_KEY = 4, T = 4, S = 3;
    localparam int NL = NUM_SW + NUM_KEY + 1, NP = NUM_KEY + 1;
    localparam logic [NL-1:0] INV = {{NP{1'b1}}, {NUM_SW{1'b0}}};

    logic                      clk = 1'b0, reset = 1'b1;
    logic [NUM_SW-1:0]         raw_sw = '0;
    logic [NUM_KEY-1:0]        raw_key = '1, key_clear = '0;
    logic                      raw_apply = 1'b1, apply_clear = 1'b0;
    logic [NUM_SW+NUM_KEY-1:0] IO_input;
    logic [NUM_KEY-1:0]        key_press, key_latched;
    logic                      apply_press, apply_latched, sample_tick;
    logic [32:0]               obs;

    int vectors = 0, miscmp = 0;

    io_input_conditioner #(.NUM_SW(NUM_SW), .NUM_KEY(NUM_KEY), .TICK_CYCLES(T),
                           .STABLE_TICKS(S), .KEY_ACTIVE_LOW(1)) dut (
        .physical_clock(clk), .reset(reset), .raw_sw(raw_sw), .raw_key(raw_key),
        .raw_apply(raw_apply), .key_clear(key_clear), .apply_clear(apply_clear),
        .IO_input(IO_input), .key_press(key_press), .key_latched(key_latched),
        .apply_press(apply_press), .apply_latched(apply_latched), .sample_tick(sample_tick));

    always #5 clk = ~clk;

    assign obs = {IO_input, key_press, key_latched, apply_press, apply_latched, sample_tick};

    // Reference model: raw delayed two cycles, sampled every T cycles; a line flips once S
    // consecutive samples disagree with its accepted level. Pulses follow accepted rises.
    logic [NL-1:0] m_r1 = '0, m_r2 = '0, m_deb = '0, m_syn = '0;
    logic [NP-1:0] m_press = '0, m_lat = '0, m_prev = '0, m_fire = '0;
    logic          m_tick = 1'b0;
    int            m_tcnt = 0;
    int            m_run[NL];
    int            m_hi[NUM_KEY];

    always @(posedge clk) begin
        if (reset) begin
            m_r1 = '0; m_r2 = '0; m_deb = '0; m_press = '0; m_lat = '0; m_prev = '0; m_tcnt = 0;
            for (int i = 0; i < NL; i++) m_run[i] = 0;
            for (int k = 0; k < NUM_KEY; k++) m_hi[k] = 0;
        end else begin
            m_tick = (m_tcnt == T - 1);
            m_syn  = m_r2 ^ INV;
            m_fire = '0;
`ifdef IO_INPUT_AUTOREPEAT_EN
            for (int k = 0; k < NUM_KEY; k++) begin
                if (!m_deb[NUM_SW+k]) m_hi[k] = 0;
                else if (m_tick) begin
                    m_hi[k]++;
                    if (m_hi[k] >= 500 && (m_hi[k] - 500) % 100 == 0) m_fire[k] = 1'b1;
                end
            end
`endif
            m_lat   = m_press | (m_lat & ~{apply_clear, key_clear});
            m_press = (m_deb[NL-1:NUM_SW] & ~m_prev) | m_fire;
            m_prev  = m_deb[NL-1:NUM_SW];
            if (m_tick) begin
                for (int i = 0; i < NL; i++) begin
                    if (m_syn[i] != m_deb[i]) begin
                        m_run[i]++;
                        if (m_run[i] == S) begin m_deb[i] = m_syn[i]; m_run[i] = 0; end
                    end else m_run[i] = 0;
                end
            end
            m_r2   = m_r1;
            m_r1   = {raw_apply, raw_key, raw_sw};
            m_tcnt = m_tick ? 0 : m_tcnt + 1;
        end
    end

    function automatic logic [32:0] exp_vec();
        return {m_deb[NUM_SW+NUM_KEY-1:0], m_press[NUM_KEY-1:0], m_lat[NUM_KEY-1:0],
                m_press[NUM_KEY], m_lat[NUM_KEY], 1'(m_tcnt == T - 1)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; raw_key = '1; raw_apply = 1'b1; raw_sw = '0;
        repeat (10) begin
            cyc();
            vectors++; if (obs !== '0) begin miscmp++; $display("FAIL reset_state got=%h exp=0", obs); end
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL reset_model got=%h exp=%h", obs, exp_vec()); end
        end
        reset = 1'b0;
        repeat (20) begin
            cyc();
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL post_reset got=%h exp=%h", obs, exp_vec()); end
            vectors++; if (key_press !== '0) begin miscmp++; $display("FAIL no_press_after_reset got=%b exp=0", key_press); end
        end
    endtask

    task automatic test_sw_debounce();
        int lat = 0;
        repeat ($urandom_range(0, 3)) cyc();
        raw_sw[5] = 1'b1;
        while (lat < 40) begin
            cyc(); lat++;
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL sw_debounce got=%h exp=%h", obs, exp_vec()); end
            if (IO_input[5]) break;
        end
        vectors++;
        if (!IO_input[5] || lat <= 2 + (S - 1) * T || lat > 2 + (S + 1) * T) begin
            miscmp++; $display("FAIL sw_latency got=%0d cycles (rose=%b) exp=%0d..%0d", lat, IO_input[5],
                               2 + (S - 1) * T + 1, 2 + (S + 1) * T);
        end
        repeat (8) begin
            cyc();
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL sw_hold got=%h exp=%h", obs, exp_vec()); end
        end
    endtask

    task automatic test_glitch();
        int ticks = 0, pulses = 0, n = 0;
        repeat ($urandom_range(0, 3)) cyc();
        raw_key[0] = 1'b0;
        repeat (2) begin
            cyc(); if (key_press[0]) pulses++;
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL glitch_pre got=%h exp=%h", obs, exp_vec()); end
        end
        while (ticks < 2 && n < 40) begin
            cyc(); n++; if (sample_tick) ticks++; if (key_press[0]) pulses++;
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL glitch_low got=%h exp=%h", obs, exp_vec()); end
        end
        raw_key[0] = 1'b1;
        repeat (T) begin
            cyc(); if (key_press[0]) pulses++;
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL glitch_high got=%h exp=%h", obs, exp_vec()); end
        end
        raw_key[0] = 1'b0;
        ticks = 0; n = 0;
        while (n < 60) begin
            cyc(); n++; if (key_press[0]) pulses++;
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL glitch_restart got=%h exp=%h", obs, exp_vec()); end
            if (IO_input[18]) break;
            if (sample_tick) ticks++;
        end
        vectors++; if (!IO_input[18] || ticks != S) begin
            miscmp++; $display("FAIL glitch_ticks got=%0d ticks (rose=%b) exp=%0d", ticks, IO_input[18], S);
        end
        raw_key[0] = 1'b1;
        repeat (30) begin
            cyc(); if (key_press[0]) pulses++;
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL glitch_release got=%h exp=%h", obs, exp_vec()); end
        end
        vectors++; if (pulses != 1) begin miscmp++; $display("FAIL glitch_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_latch_clear();
        int n = 0;
        raw_key[1] = 1'b0;
        while (n < 60) begin
            cyc(); n++;
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL latch_wait got=%h exp=%h", obs, exp_vec()); end
            if (key_press[1]) break;
        end
        vectors++; if (!key_press[1]) begin miscmp++; $display("FAIL latch_press_seen got=0 exp=1"); end
        key_clear[1] = 1'b1;
        cyc();
        vectors++; if (key_latched[1] !== 1'b1) begin miscmp++; $display("FAIL set_beats_clear got=%b exp=1", key_latched[1]); end
        vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL latch_set got=%h exp=%h", obs, exp_vec()); end
        cyc();
        vectors++; if (key_latched[1] !== 1'b0) begin miscmp++; $display("FAIL clear_latch got=%b exp=0", key_latched[1]); end
        cyc();
        vectors++; if (key_latched[1] !== 1'b0) begin miscmp++; $display("FAIL clear_idle got=%b exp=0", key_latched[1]); end
        key_clear[1] = 1'b0; raw_key[1] = 1'b1;
        repeat (30) begin
            cyc();
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL latch_release got=%h exp=%h", obs, exp_vec()); end
        end
    endtask

    task automatic test_reset_mid();
        int ticks = 0, n = 0, pulses = 0, at = -1;
        raw_apply = 1'b0;
        repeat (2) begin
            cyc();
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL rmid_sync got=%h exp=%h", obs, exp_vec()); end
        end
        while (ticks < 2 && n < 40) begin
            cyc(); n++; if (sample_tick) ticks++;
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL rmid_changing got=%h exp=%h", obs, exp_vec()); end
        end
        cyc();
        reset = 1'b1;
        repeat (2) begin
            cyc();
            vectors++; if (obs !== '0) begin miscmp++; $display("FAIL rmid_reset got=%h exp=0", obs); end
        end
        reset = 1'b0; ticks = 0;
        repeat (60) begin
            cyc();
            if (apply_press) begin pulses++; at = ticks; end
            if (sample_tick) ticks++;
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL rmid_after got=%h exp=%h", obs, exp_vec()); end
        end
        vectors++; if (pulses != 1 || at < S || at > S + 1) begin
            miscmp++; $display("FAIL rmid_apply got=%0d pulses at tick %0d exp=1 pulse at %0d..%0d", pulses, at, S, S + 1);
        end
        raw_apply = 1'b1;
        repeat (30) cyc();
    endtask

    task automatic test_random();
        repeat (1200) begin
            if ($urandom_range(0, 15) == 0) begin
                int b = $urandom_range(0, NL - 1);
                if (b < NUM_SW) raw_sw[b] = ~raw_sw[b];
                else if (b < NUM_SW + NUM_KEY) raw_key[b-NUM_SW] = ~raw_key[b-NUM_SW];
                else raw_apply = ~raw_apply;
            end
            key_clear   = ($urandom_range(0, 7) == 0) ? NUM_KEY'($urandom) : '0;
            apply_clear = ($urandom_range(0, 7) == 0);
            cyc();
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL random got=%h exp=%h", obs, exp_vec()); end
        end
        raw_key = '1; raw_apply = 1'b1; key_clear = '1; apply_clear = 1'b1;
        repeat (40) cyc();
        key_clear = '0; apply_clear = 1'b0;
        cyc();
    endtask

    task automatic test_hold();
`ifdef IO_INPUT_AUTOREPEAT_EN
        int hold_ticks = 790, exp_pulses = 4;
`else
        int hold_ticks = 600, exp_pulses = 1;
`endif
        int pulses = 0;
        raw_key[2] = 1'b0;
        repeat (hold_ticks * T) begin
            cyc(); if (key_press[2]) pulses++;
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL hold got=%h exp=%h", obs, exp_vec()); end
        end
        raw_key[2] = 1'b1;
        repeat (60) begin
            cyc(); if (key_press[2]) pulses++;
            vectors++; if (obs !== exp_vec()) begin miscmp++; $display("FAIL hold_release got=%h exp=%h", obs, exp_vec()); end
        end
        vectors++; if (pulses != exp_pulses) begin miscmp++; $display("FAIL hold_pulses got=%0d exp=%0d", pulses, exp_pulses); end
    endtask

    initial begin
        test_reset();
        test_sw_debounce();
        test_glitch();
        test_latch_clear();
        test_reset_mid();
        test_random();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end
endmodule
